seg7_scan_decoder: RTL and testbench

- Receives the scanned 7-segment bus (segment byte plus active-low one-hot anode select) that the board display driver emits, and rebuilds the 8-digit, 64-bit frame behind it.
- It is the decoder for the display encoder. It is used for on-board loopback self-check and as a bench monitor.
- Optional hex mode maps each segment pattern back to a 4-bit nibble, producing a 32-bit value.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_stable_filter.sv | 59 +++++
 rtl/seg7_scan_decoder.sv | 105 ++++++++++
 tb/tb_seg7_scan_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned 7-segment display path: segment bit order,
// the hex glyph table and the reverse glyph lookup.
package seg7_pkg;

  // Active-low segment byte layout as it appears on the bus.
  typedef struct packed {
    logic dp;
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  // Active-low glyphs for nibbles 0..F; index n holds the glyph for value n.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [6:0] seg_key(input logic [7:0] seg);
    seg_t s;
    s = seg_t'(seg);
    return {s.g, s.f, s.e, s.d, s.c, s.b, s.a};
  endfunction

  // Returns {miss, nibble}; the decimal point never affects the match.
  function automatic logic [4:0] hex_lookup(input logic [7:0] seg);
    logic [4:0] res;
    res = 5'h10;
    for (int i = 15; i >= 0; i--) begin
      if (seg_key(seg) == seg_key(SEG_HEX[i])) res = {1'b0, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Input synchronizer plus dwell filter: emits one accept pulse per input value
// that stays unchanged for STABLE_CYC synchronized samples.
module seg7_stable_filter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_accept
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CntAcc = CNT_W'(STABLE_CYC - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_s;
  logic             w_same;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_accept;
  logic             w_done_d;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_same   = (w_s == r_prev);
    w_cnt_d  = '0;
    if (w_same) w_cnt_d = (r_cnt == CntMax) ? r_cnt : r_cnt + CNT_W'(1);
    // Fires on the transition into STABLE_CYC-1, so a dwell yields at most one accept.
    w_accept = w_same && !r_done && (w_cnt_d == CntAcc);
    w_done_d = w_same && (r_done || w_accept);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_sync[0] <= i_data;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s;
      r_cnt  <= w_cnt_d;
      r_done <= w_done_d;
    end
  end

  assign o_data   = w_s;
  assign o_accept = w_accept;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Rebuilds the 8-digit frame from a scanned 7-segment bus (segment byte plus
// active-low one-hot anode select), with optional glyph-to-nibble decoding.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg_i,
  input  logic [7:0]  an_i,
  input  logic        hex_mode_i,
  output logic [63:0] frame_data_o,
  output logic [31:0] hex_data_o,
  output logic        frame_valid_o,
  output logic        hex_err_o,
  output logic        sel_err_o,
  output logic [7:0]  digit_mask_o
);

  logic [15:0] w_s;
  logic        w_accept;
  logic [7:0]  w_seg;
  logic [7:0]  w_an_n;
  logic        w_single;
  logic        w_multi;
  logic        w_cap;
  logic [4:0]  w_lut;

  logic [7:0][7:0] r_slot;
  logic [7:0][3:0] r_nib;
  logic [7:0]      r_bad;
  logic [7:0]      r_mask;
  logic [63:0]     r_frame;
  logic [31:0]     r_hex;
  logic            r_valid;
  logic            r_hex_err;
  logic            r_sel_err;

  seg7_stable_filter #(
    .WIDTH      (16),
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYC (STABLE_CYC),
    .CNT_W      (CNT_W)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .i_data  ({seg_i, an_i}),
    .o_data  (w_s),
    .o_accept(w_accept)
  );

  always_comb begin
    w_seg    = w_s[15:8];
    w_an_n   = ~w_s[7:0];
    w_single = (w_an_n != 8'h00) && ((w_an_n & (w_an_n - 8'd1)) == 8'h00);
    w_multi  = (w_an_n != 8'h00) && !w_single;
    w_cap    = w_accept && w_single;
    w_lut    = hex_lookup(w_seg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot    <= '0;
      r_nib     <= '0;
      r_bad     <= '0;
      r_mask    <= '0;
      r_frame   <= '0;
      r_hex     <= '0;
      r_valid   <= 1'b0;
      r_hex_err <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_sel_err <= w_accept && w_multi;
      for (int k = 0; k < 8; k++) begin
        if (w_cap && w_an_n[k]) begin
          r_slot[k] <= w_seg;
          r_nib[k]  <= w_lut[3:0];
          r_bad[k]  <= w_lut[4];
        end
      end
      if (r_mask == 8'hFF) begin
        r_frame   <= r_slot;
        r_hex     <= r_nib;
        r_hex_err <= hex_mode_i & (|r_bad);
        r_valid   <= 1'b1;
        // A capture landing on the completion cycle starts the next frame.
        r_mask    <= w_cap ? w_an_n : 8'h00;
      end else if (w_cap) begin
        r_mask <= r_mask | w_an_n;
      end
    end
  end

  assign frame_data_o  = r_frame;
  assign hex_data_o    = r_hex;
  assign frame_valid_o = r_valid;
  assign hex_err_o     = r_hex_err;
  assign sel_err_o     = r_sel_err;
  assign digit_mask_o  = r_mask;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: stimulus tasks feed a digit-level reference model that queues
// expected frames; a negedge monitor pops and compares on each frame_valid_o.
module tb_seg7_scan_decoder;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned StableCyc  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  seg_i = 8'hFF;
  logic [7:0]  an_i = 8'hFF;
  logic        hex_mode_i = 1'b0;
  logic [63:0] frame_data_o;
  logic [31:0] hex_data_o;
  logic        frame_valid_o;
  logic        hex_err_o;
  logic        sel_err_o;
  logic [7:0]  digit_mask_o;

  seg7_scan_decoder #(
    .SYNC_STAGES(SyncStages),
    .STABLE_CYC (StableCyc),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_i        (seg_i),
    .an_i         (an_i),
    .hex_mode_i   (hex_mode_i),
    .frame_data_o (frame_data_o),
    .hex_data_o   (hex_data_o),
    .frame_valid_o(frame_valid_o),
    .hex_err_o    (hex_err_o),
    .sel_err_o    (sel_err_o),
    .digit_mask_o (digit_mask_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] frame;
    logic [31:0] hex;
    logic [31:0] hexmask;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          sel_seen = 0;
  int          m_sel = 0;
  int          m_frames = 0;
  logic [7:0]  m_slot [8];
  logic [7:0]  m_mask = 8'h00;
  logic [7:0]  hextab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Digit glyph back to value; -1 when the glyph is not a hex digit.
  function automatic int ref_hex(input logic [7:0] s);
    for (int n = 0; n < 16; n++) begin
      if (s[6:0] == hextab[n][6:0]) return n;
    end
    return -1;
  endfunction

  task automatic model_digit(input logic [7:0] seg, input logic [7:0] an, input int d);
    int   zeros;
    int   k;
    int   v;
    exp_t e;
    if (d < StableCyc) return;
    zeros = 8 - $countones(an);
    if (zeros >= 2) begin
      m_sel++;
    end else if (zeros == 1) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (!an[i]) k = i;
      m_slot[k] = seg;
      m_mask[k] = 1'b1;
      if (m_mask == 8'hFF) begin
        e.frame = '0; e.hex = '0; e.hexmask = '0; e.err = 1'b0;
        for (int i = 0; i < 8; i++) begin
          e.frame[8*i +: 8] = m_slot[i];
          v = ref_hex(m_slot[i]);
          if (v < 0) e.err = 1'b1;
          else begin
            e.hex[4*i +: 4]     = v[3:0];
            e.hexmask[4*i +: 4] = 4'hF;
          end
        end
        e.err = e.err & hex_mode_i;
        q.push_back(e);
        m_frames++;
        m_mask = 8'h00;
      end
    end
  endtask

  task automatic idle(input int n);
    seg_i = 8'hFF;
    an_i  = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  // One-cycle blank separator keeps adjacent identical dwells from merging.
  task automatic dwell(input logic [7:0] seg, input logic [7:0] an, input int d);
    idle(1);
    model_digit(seg, an, d);
    seg_i = seg;
    an_i  = an;
    repeat (d) @(negedge clk);
  endtask

  task automatic check_mask(input string name);
    idle(10);
    chk(name, {56'h0, digit_mask_o}, {56'h0, m_mask});
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_frame"}, frame_data_o, 64'h0);
    chk({tag, "_hex"}, {32'h0, hex_data_o}, 64'h0);
    chk({tag, "_valid"}, {63'h0, frame_valid_o}, 64'h0);
    chk({tag, "_hexerr"}, {63'h0, hex_err_o}, 64'h0);
    chk({tag, "_selerr"}, {63'h0, sel_err_o}, 64'h0);
    chk({tag, "_mask"}, {56'h0, digit_mask_o}, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      seg_i = 8'($urandom);
      an_i  = 8'($urandom);
      @(negedge clk);
    end
    check_zero_outputs("reset");
    seg_i  = 8'hFF;
    an_i   = 8'hFF;
    m_mask = 8'h00;
    reset  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (sel_err_o) sel_seen++;
      if (frame_valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_frame", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("frame_data", frame_data_o, e.frame);
          chk("hex_data", {32'h0, hex_data_o & e.hexmask}, {32'h0, e.hex});
          chk("hex_err", {63'h0, hex_err_o}, {63'h0, e.err});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_slot[i] = 8'h00;
    repeat (3) begin
      seg_i = 8'($urandom);
      an_i  = 8'($urandom);
      @(negedge clk);
    end
    check_zero_outputs("por");
    seg_i = 8'hFF;
    an_i  = 8'hFF;
    reset = 1'b0;
    idle(12);
    check_zero_outputs("post_reset");

    // Raw frame, sequential scan.
    hex_mode_i = 1'b0;
    for (int k = 0; k < 8; k++) dwell(8'((k + 1) * 8'h11), ~(8'h01 << k), 8);
    idle(10);
    chk("raw_frame_const", frame_data_o, 64'h8877665544332211);

    // Hex frame, then the same with an unknown glyph on digit 3.
    hex_mode_i = 1'b1;
    for (int k = 0; k < 8; k++) dwell(hextab[k], ~(8'h01 << k), 6);
    idle(10);
    chk("hex_const", {32'h0, hex_data_o}, 64'h76543210);
    chk("hex_err_clear", {63'h0, hex_err_o}, 64'h0);
    for (int k = 0; k < 8; k++) dwell((k == 3) ? 8'hFF : hextab[k], ~(8'h01 << k), 6);
    idle(10);
    chk("hex_err_set", {63'h0, hex_err_o}, 64'h1);
    hex_mode_i = 1'b0;

    // Glitch filter: 3-cycle dwell rejected, 4-cycle dwell captured.
    dwell(8'hA0, 8'hFE, 5);
    dwell(8'hA1, 8'hFD, 5);
    dwell(8'hA2, 8'hFB, 3);
    check_mask("glitch_reject");
    dwell(8'hA2, 8'hFB, 4);
    check_mask("glitch_accept");

    // Multi-select error and blank selects.
    dwell(8'h55, 8'hFC, 6);
    check_mask("selerr_mask");
    dwell(8'h66, 8'hFF, 6);
    check_mask("blank_mask");
    for (int k = 3; k < 8; k++) dwell(8'hB0 + 8'(k), ~(8'h01 << k), 5);
    idle(10);

    // Reset mid-frame discards the partial digits.
    for (int k = 0; k < 5; k++) dwell(8'hC0 + 8'(k), ~(8'h01 << k), 5);
    do_reset();
    check_mask("midframe_reset");
    for (int k = 0; k < 3; k++) dwell(8'hD0 + 8'(k), ~(8'h01 << k), 5);
    check_mask("after_reset_partial");
    for (int k = 0; k < 8; k++) dwell(8'hE0 + 8'(k), ~(8'h01 << k), 5);
    idle(10);

    // Randomized frames: random order, re-captures, short dwells, blanks, multi-selects.
    for (int f = 0; f < 20; f++) begin
      int start;
      int iter;
      start = m_frames;
      iter  = 0;
      hex_mode_i = 1'($urandom);
      while (m_frames == start && iter < 400) begin
        logic [7:0] seg;
        logic [7:0] an;
        int         r;
        int         a;
        int         b;
        r = int'($urandom_range(0, 15));
        a = int'($urandom_range(0, 7));
        if (r < 12) seg = hextab[$urandom_range(0, 15)] ^ {1'($urandom), 7'h0};
        else        seg = 8'($urandom);
        if (r == 13) begin
          b  = (a + int'($urandom_range(1, 7))) % 8;
          an = ~((8'h01 << a) | (8'h01 << b));
        end else if (r == 14) begin
          an = 8'hFF;
        end else begin
          an = ~(8'h01 << a);
        end
        dwell(seg, an, int'($urandom_range(2, 9)));
        iter++;
      end
      chk("rand_frame_done", 64'(m_frames - start), 64'd1);
      idle(12);
    end

    idle(20);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("sel_err_count", 64'(sel_seen), 64'(m_sel));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
